demux_lane_scheduler: RTL

//   Sequences the 1:2 byte demux on the clk_2f domain: steers each accepted input word to lane 0 or lane 1.

---
 rtl/demux_lane_scheduler_if.sv | 25 ++
 rtl/demux_lane_scheduler.sv | 109 ++++++++++
 2 files changed

// File: rtl/demux_lane_scheduler_if.sv
// Upstream handshake, lane pause inputs and lane output bus of the 1:2 demux lane scheduler.
// The master side drives words and pauses; the slave side is the scheduler.
interface demux_lane_scheduler_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic              pause_0;
  logic              pause_1;
  logic [DATA_W-1:0] data_out_0;
  logic              valid_out_0;
  logic [DATA_W-1:0] data_out_1;
  logic              valid_out_1;

  modport master (
    output data_in, valid_in, pause_0, pause_1,
    input  ready_in, data_out_0, valid_out_0, data_out_1, valid_out_1
  );

  modport slave (
    input  data_in, valid_in, pause_0, pause_1,
    output ready_in, data_out_0, valid_out_0, data_out_1, valid_out_1
  );
endinterface

// File: rtl/demux_lane_scheduler.sv
// Steers each accepted input word to lane 0 or lane 1 on clk_2f, round-robin with pause handling,
// plus per-lane word counters and a saturating stall counter.
module demux_lane_scheduler #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 8,
  parameter bit          SKIP_PAUSED = 1'b1
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  demux_lane_scheduler_if.slave bus,
  output logic                  next_lane,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      cnt_0,
  output logic [CNT_W-1:0]      cnt_1,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRoute = 2'd1,
    StStall = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_0_q, data_1_q;
  logic                valid_0_q, valid_1_q;
  logic                next_lane_q;
  logic [CNT_W-1:0]    cnt_0_q, cnt_1_q, stall_cnt_q;

  logic pause_pref, pause_alt;
  logic has_tgt, tgt;
  logic ready, accept, stall;

  // Preferred lane first; the other lane only when skipping is enabled.
  always_comb begin
    pause_pref = next_lane_q ? bus.pause_1 : bus.pause_0;
    pause_alt  = next_lane_q ? bus.pause_0 : bus.pause_1;
    has_tgt    = 1'b0;
    tgt        = next_lane_q;
    if (!pause_pref) begin
      has_tgt = 1'b1;
    end else if (SKIP_PAUSED && !pause_alt) begin
      has_tgt = 1'b1;
      tgt     = ~next_lane_q;
    end
    ready  = !reset && has_tgt;
    accept = bus.valid_in && ready;
    stall  = bus.valid_in && !ready;
  end

  always_comb begin
    state_d = StIdle;
    if (accept) begin
      state_d = StRoute;
    end else if (stall) begin
      state_d = StStall;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_0_q    <= '0;
      data_1_q    <= '0;
      valid_0_q   <= 1'b0;
      valid_1_q   <= 1'b0;
      next_lane_q <= 1'b0;
      cnt_0_q     <= '0;
      cnt_1_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_0_q <= accept && !tgt;
      valid_1_q <= accept && tgt;
      if (accept) begin
        // A skip leaves next_lane on the skipped lane so it keeps priority.
        next_lane_q <= ~tgt;
        if (tgt) begin
          data_1_q <= bus.data_in;
          cnt_1_q  <= cnt_1_q + CNT_W'(1);
        end else begin
          data_0_q <= bus.data_in;
          cnt_0_q  <= cnt_0_q + CNT_W'(1);
        end
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ready_in    = ready;
  assign bus.data_out_0  = data_0_q;
  assign bus.valid_out_0 = valid_0_q;
  assign bus.data_out_1  = data_1_q;
  assign bus.valid_out_1 = valid_1_q;
  assign next_lane       = next_lane_q;
  assign state_o         = state_q;
  assign cnt_0           = cnt_0_q;
  assign cnt_1           = cnt_1_q;
  assign stall_cnt       = stall_cnt_q;

endmodule
